// File: rtl/md_pkg.sv
// md_pkg: shared MD-class, MDU-op and FSM encodings for the MDU issue path.
package md_pkg;
  typedef enum logic [3:0] {
    CLS_NONE  = 4'd0,
    CLS_MULT  = 4'd1,
    CLS_MULTU = 4'd2,
    CLS_DIV   = 4'd3,
    CLS_DIVU  = 4'd4,
    CLS_MTHI  = 4'd5,
    CLS_MTLO  = 4'd6,
    CLS_MFHI  = 4'd7,
    CLS_MFLO  = 4'd8
  } md_cls_e;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;
  localparam logic [2:0] IDLE_OP = 3'b111;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;
  // MULT..MTLO map onto consecutive op codes, so the decode is an offset.
  function automatic logic [2:0] cls2op(input logic [3:0] cls);
    return (cls >= 4'd1 && cls <= 4'd6) ? 3'(cls - 4'd1) : IDLE_OP;
  endfunction
endpackage

// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: E-stage MD instruction, MDU handshake and M-stage return bundle.
interface md_issue_ctrl_if #(parameter int CNT_W = 32);
  logic             e_valid;
  logic [3:0]       e_cls;
  logic [31:0]      e_rs;
  logic [31:0]      e_rt;
  logic             req;
  logic             md_busy;
  logic [31:0]      md_hi;
  logic [31:0]      md_lo;
  logic             md_start;
  logic [2:0]       md_op;
  logic [31:0]      md_rd1;
  logic [31:0]      md_rd2;
  logic             md_req;
  logic             stall;
  logic [31:0]      mf_data;
  logic             mf_valid;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    input  e_valid, e_cls, e_rs, e_rt, req, md_busy, md_hi, md_lo,
    output md_start, md_op, md_rd1, md_rd2, md_req, stall, mf_data, mf_valid, stall_cnt
  );
  modport slave (
    output e_valid, e_cls, e_rs, e_rt, req, md_busy, md_hi, md_lo,
    input  md_start, md_op, md_rd1, md_rd2, md_req, stall, mf_data, mf_valid, stall_cnt
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage MDU issue, op hold while busy, pipeline stall,
// MFHI/MFLO return to M and a saturating stall-cycle counter.
module md_issue_ctrl #(
  parameter logic [2:0] IDLE_OP = md_pkg::IDLE_OP,
  parameter int         CNT_W   = 32
) (
  input logic              clk,
  input logic              reset,
  md_issue_ctrl_if.master  bus
);
  import md_pkg::*;
  md_state_e        state_q, state_d;
  logic [2:0]       held_q, held_d;
  logic [31:0]      mf_data_q, mf_data_d;
  logic             mf_valid_q, mf_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_md, go, idle, issue, mt, mf;
  // md_start is decoded only from IDLE, never from stall, so md_busy has no comb path back to it.
  always_comb begin
    is_md          = bus.e_cls >= 4'd1 && bus.e_cls <= 4'd8;
    go             = bus.e_valid & is_md & ~bus.req;
    idle           = state_q == IDLE;
    issue          = idle & go & (bus.e_cls <= 4'd4);
    mt             = idle & go & (bus.e_cls == CLS_MTHI || bus.e_cls == CLS_MTLO);
    mf             = idle & go & (bus.e_cls >= 4'd7);
    bus.md_start   = issue;
    bus.md_op      = !idle ? held_q : (issue | mt) ? cls2op(bus.e_cls) : IDLE_OP;
    bus.stall      = !idle & bus.e_valid & is_md;
    bus.md_req     = bus.req;
    bus.md_rd1     = bus.e_rs;
    bus.md_rd2     = bus.e_rt;
    bus.mf_data    = mf_data_q;
    bus.mf_valid   = mf_valid_q;
    bus.stall_cnt  = cnt_q;
    state_d        = issue ? BUSY : (!idle && !bus.md_busy) ? IDLE : state_q;
    held_d         = issue ? cls2op(bus.e_cls) : held_q;
    mf_valid_d     = mf;
    mf_data_d      = mf ? (bus.e_cls == CLS_MFHI ? bus.md_hi : bus.md_lo) : mf_data_q;
    cnt_d          = (bus.stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      held_q     <= IDLE_OP;
      mf_data_q  <= '0;
      mf_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      mf_data_q  <= mf_data_d;
      mf_valid_q <= mf_valid_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule
